// File: rtl/rv32_dbus_ahb_master.sv
// rv32_dbus_ahb_master
// Data-bus AHB-Lite master for the RV32I core. Turns each load/store request
// (address, lane-positioned data, byte mask) into one pipelined SINGLE
// transfer, absorbs wait states and two-cycle ERROR responses, and returns a
// one-cycle response pulse with read data and error status.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-low reset
//   req_in .. mask_in       core request (held until ack_out)
//   ack_out                 request accepted this cycle (combinational)
//   rsp_valid_out           one-cycle response pulse
//   rdata_out, err_out      response payload, valid with rsp_valid_out
//   haddr_out .. hwdata_out AHB-Lite master outputs
//   hrdata_in, hready_in,
//   hresp_in                AHB-Lite slave response
//
// state  | meaning
// IDLE   | no data phase outstanding
// DATA   | data phase in progress
// ERR2   | second cycle of an ERROR response
// BADRSP | illegal-mask response being returned
module rv32_dbus_ahb_master (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_in,
    input  logic        wr_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [3:0]  mask_in,
    output logic        ack_out,
    output logic        rsp_valid_out,
    output logic [31:0] rdata_out,
    output logic        err_out,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [2:0]  hsize_out,
    output logic [2:0]  hburst_out,
    output logic [3:0]  hprot_out,
    output logic [31:0] hwdata_out,
    input  logic [31:0] hrdata_in,
    input  logic        hready_in,
    input  logic        hresp_in
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_ERR2   = 2'd2,
        ST_BADRSP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        wr_q;
    logic [31:0] hwdata_q;
    logic        rsp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        legal;
    logic [1:0]  lane;
    logic [2:0]  size;
    logic        start;
    logic        bad_ack;
    logic        rsp_set;
    logic        rsp_err;
    logic [31:0] rsp_data;

    // Low address bits come from the mask, never from the core.
    logic        unused_addr_lo;
    assign unused_addr_lo = ^addr_in[1:0];

    always_comb begin
        legal = 1'b1;
        lane  = 2'd0;
        size  = 3'd0;
        case (mask_in)
            4'b0001: begin lane = 2'd0; size = 3'd0; end
            4'b0010: begin lane = 2'd1; size = 3'd0; end
            4'b0100: begin lane = 2'd2; size = 3'd0; end
            4'b1000: begin lane = 2'd3; size = 3'd0; end
            4'b0011: begin lane = 2'd0; size = 3'd1; end
            4'b1100: begin lane = 2'd2; size = 3'd1; end
            4'b1111: begin lane = 2'd0; size = 3'd2; end
            default: legal = 1'b0;
        endcase
    end

    // The first ERROR cycle (hresp high in DATA) cancels any overlapping
    // address phase; the request stays pending and is re-issued later.
    assign start   = req_in & legal & hready_in &
                     ((state_q == ST_IDLE) | ((state_q == ST_DATA) & ~hresp_in));
    // Illegal masks only in IDLE so their response cannot overtake a transfer.
    assign bad_ack = req_in & ~legal & (state_q == ST_IDLE);

    assign ack_out    = start | bad_ack;
    assign htrans_out = start ? 2'b10 : 2'b00;
    assign haddr_out  = {addr_in[31:2], lane};
    assign hwrite_out = wr_in;
    assign hsize_out  = size;
    assign hburst_out = 3'b000;
    assign hprot_out  = 4'b0011;

    assign hwdata_out    = hwdata_q;
    assign rsp_valid_out = rsp_valid_q;
    assign rdata_out     = rdata_q;
    assign err_out       = err_q;

    always_comb begin
        state_d  = state_q;
        rsp_set  = 1'b0;
        rsp_err  = 1'b0;
        rsp_data = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DATA;
                end else if (bad_ack) begin
                    state_d = ST_BADRSP;
                    rsp_set = 1'b1;
                    rsp_err = 1'b1;
                end
            end
            ST_DATA: begin
                if (hready_in & ~hresp_in) begin
                    rsp_set  = 1'b1;
                    rsp_data = wr_q ? 32'd0 : hrdata_in;
                    state_d  = start ? ST_DATA : ST_IDLE;
                end else if (hresp_in) begin
                    state_d = ST_ERR2;
                end
            end
            ST_ERR2: begin
                if (hready_in) begin
                    rsp_set = 1'b1;
                    rsp_err = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_BADRSP: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            hwdata_q    <= 32'd0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_set;
            if (start) begin
                wr_q <= wr_in;
                if (wr_in) hwdata_q <= wdata_in;
            end
            if (rsp_set) begin
                rdata_q <= rsp_data;
                err_q   <= rsp_err;
            end
        end
    end

endmodule

// File: doc/rv32_dbus_ahb_master.md
# rv32_dbus_ahb_master

Data-bus AHB-Lite master for the RV32I core. It sits directly downstream of the store unit and the load path. It accepts one memory request per handshake: address, write data and byte-lane write mask. It converts each request into a single pipelined AHB-Lite transfer, handles wait states and two-cycle ERROR responses, and returns read data and status to the core.

## Interface

Parameters: none.

Ports:
- clk_in  input  1  core clock; all state on rising edge
- rst_in  input  1  reset, asynchronous, active-low
- req_in  input  1  request valid; held stable with all request fields until ack_out
- wr_in  input  1  1 = store, 0 = load
- addr_in  input  32  byte address; bits [1:0] are ignored and re-derived from the mask
- wdata_in  input  32  lane-positioned store data (store unit data_out)
- mask_in  input  4  byte-lane mask (store unit wr_mask_out, or load-unit equivalent)
- ack_out  output  1  request accepted this cycle (combinational)
- rsp_valid_out  output  1  one-cycle pulse: transfer finished
- rdata_out  output  32  HRDATA captured for loads; 0 for stores
- err_out  output  1  qualifies rsp_valid_out: bus error or illegal mask
- haddr_out  output  32  AHB address
- htrans_out  output  2  2'b00 IDLE, 2'b10 NONSEQ only
- hwrite_out  output  1  AHB direction
- hsize_out  output  3  0 byte, 1 half, 2 word
- hburst_out  output  3  constant 3'b000 (SINGLE)
- hprot_out  output  4  constant 4'b0011
- hwdata_out  output  32  write data, driven in the data phase
- hrdata_in  input  32  AHB read data
- hready_in  input  1  AHB ready
- hresp_in  input  1  AHB response: 0 OKAY, 1 ERROR

## Operation

Mask decode (combinational):
- 0001, 0010, 0100, 1000: byte transfer; haddr[1:0] = 0, 1, 2, 3.
- 0011, 1100: half-word transfer; haddr[1:0] = 0, 2.
- 1111: word transfer; haddr[1:0] = 0.
- Any other value, including 0000: illegal.

State machine: IDLE, DATA, ERR2, BADRSP.
- IDLE: no data phase outstanding.
- DATA: data phase in progress.
- ERR2: second cycle of an ERROR response.
- BADRSP: pending illegal-mask response.

Address phase (combinational):
- A legal request may start in IDLE, or in DATA when hready_in = 1.
- When it starts: htrans_out = NONSEQ; haddr, hwrite and hsize are taken from the request.
- ack_out = req_in & legal & hready_in & (state is IDLE or DATA).
- htrans_out is IDLE in ERR2 and BADRSP.
- htrans_out is IDLE in DATA whenever hresp_in = 1. The first error cycle cancels the pipelined address phase; that request is not acked and stays pending.

On ack: register wr and wdata.
- hwdata_out = registered wdata for the whole data phase; stores only, otherwise held.
- Next state is DATA.

DATA, on hready_in = 1 and hresp_in = 0 (completion):
- rsp_valid_out = 1 next cycle.
- rdata_out = hrdata_in if load, else 0.
- err_out = 0.
- Next state is DATA if a new request was acked in the same cycle, else IDLE.

DATA, on hready_in = 0 and hresp_in = 1:
- Go to ERR2.

ERR2:
- Expect hready_in = 1 and hresp_in = 1.
- Then rsp_valid_out = 1 and err_out = 1 next cycle, rdata_out = 0.
- Go to IDLE.
- While in ERR2 with hready_in = 0, stay in ERR2.

Illegal mask:
- Accepted only in IDLE: ack_out = 1 and no bus transfer.
- Go to BADRSP; next cycle rsp_valid_out = 1, err_out = 1, then IDLE.
- Never reorders with an outstanding transfer.

## Timing

Reset (rst_in low, asynchronous):
- State IDLE; htrans_out = IDLE.
- rsp_valid_out, err_out = 0; rdata_out, hwdata_out = 0.
- Constants still driven.
- Reset mid-transfer abandons the transfer with no response.

Latency:
- Ack in cycle N (address phase); data phase in N+1.
- Zero wait: rsp_valid_out in N+2. Each wait state adds one cycle.

Throughput:
- Back-to-back requests sustain one transfer per cycle.
- A new address phase overlaps the previous data phase.

Stability:
- ack_out, htrans_out and haddr_out are combinational from request inputs and state.
- The core must hold request fields while ack_out = 0.
- AHB address stability under hready_in = 0 relies on that rule.

Registered outputs:
- rsp_valid_out is high for exactly one cycle per accepted request.
- rdata_out and err_out are valid only with rsp_valid_out.

## Test plan

- Word store, 0x1000 / 0xDEADBEEF / 1111, hready_in = 1 -> NONSEQ with HSIZE = 2 and HWRITE = 1 in N; HWDATA = 0xDEADBEEF in N+1; rsp_valid_out in N+2 with err_out = 0.
- Byte load, addr 0x2000 / mask 0100, two wait states, hrdata_in = 0x00AB0000 -> haddr = 0x2002, HSIZE = 0; rsp_valid_out at N+4 with rdata_out = 0x00AB0000.
- Back-to-back half stores (mask 0011 then 1100) -> second NONSEQ coincides with the first data phase; two responses on consecutive cycles.
- ERROR response with a pipelined request pending -> HTRANS = IDLE in the first error cycle; response with err_out = 1; pending request re-issued and acked afterwards.
- Mask 0101 in IDLE -> ack_out = 1; no HTRANS activity; next cycle rsp_valid_out = 1 with err_out = 1. Same mask while in DATA -> no ack until IDLE.
- rst_in low during a wait state -> all outputs return to reset values immediately; no response issued after release.
